// File: rtl/swerv_trace_unpacker_if.sv
// -----------------------------------------------------------------------------
// swerv_trace_unpacker_if
//
// Bundles the trace-packet input bus and the unpacked record stream of
// swerv_trace_unpacker.
//
// Modports:
//   slave  - the unpacker. It receives the trace packet and out_ready, and it
//            drives the record stream and the status outputs.
//   master - the environment. It drives the trace packet and out_ready, and it
//            observes the record stream and the status outputs.
//
// Signals:
//   trace_rv_i_*_ip   3-lane retire bundle; lane k occupies bit k or [32k+31:32k]
//   out_valid/ready   record handshake
//   out_lane..tval    one unpacked instruction record
//   fifo_level        occupied packet entries (0..DEPTH)
//   drop_cnt          saturating count of packets dropped on overflow
//   overflow          sticky drop flag
// -----------------------------------------------------------------------------
interface swerv_trace_unpacker_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [2:0]       trace_rv_i_valid_ip;
    logic [95:0]      trace_rv_i_insn_ip;
    logic [95:0]      trace_rv_i_address_ip;
    logic [2:0]       trace_rv_i_exception_ip;
    logic [4:0]       trace_rv_i_ecause_ip;
    logic [2:0]       trace_rv_i_interrupt_ip;
    logic [31:0]      trace_rv_i_tval_ip;

    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_lane;
    logic [31:0]      out_insn;
    logic [31:0]      out_addr;
    logic             out_exc;
    logic             out_intr;
    logic [4:0]       out_ecause;
    logic [31:0]      out_tval;

    logic [LVL_W-1:0] fifo_level;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    modport slave (
        input  trace_rv_i_valid_ip, trace_rv_i_insn_ip, trace_rv_i_address_ip,
               trace_rv_i_exception_ip, trace_rv_i_ecause_ip,
               trace_rv_i_interrupt_ip, trace_rv_i_tval_ip, out_ready,
        output out_valid, out_lane, out_insn, out_addr, out_exc, out_intr,
               out_ecause, out_tval, fifo_level, drop_cnt, overflow
    );

    modport master (
        output trace_rv_i_valid_ip, trace_rv_i_insn_ip, trace_rv_i_address_ip,
               trace_rv_i_exception_ip, trace_rv_i_ecause_ip,
               trace_rv_i_interrupt_ip, trace_rv_i_tval_ip, out_ready,
        input  out_valid, out_lane, out_insn, out_addr, out_exc, out_intr,
               out_ecause, out_tval, fifo_level, drop_cnt, overflow
    );
endinterface

// File: rtl/swerv_trace_unpacker.sv
// -----------------------------------------------------------------------------
// swerv_trace_unpacker
//
// Receives the per-cycle 3-lane instruction-trace packet and stores each
// packet that has any valid lane in a DEPTH-entry FIFO. It then emits the
// stored packets one valid lane per beat on a valid/ready stream. Packets
// leave in arrival order, and the lanes of each packet leave in ascending
// order. A packet that arrives while the FIFO is full is dropped, unless
// the head packet pops in the same cycle. Each drop increments drop_cnt,
// which saturates, and sets the sticky overflow flag.
//
// Ports:
//   clk   core clock
//   rst   synchronous, active-high reset
//   bus   swerv_trace_unpacker_if.slave (trace inputs, record stream, status)
//
// Configuration:
//   RV_TRACE_TVAL_EN - when defined, every entry stores the shared tval, and
//                      out_tval returns it on flagged records. When undefined,
//                      tval is not stored and out_tval is tied to 0.
// -----------------------------------------------------------------------------
module swerv_trace_unpacker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    swerv_trace_unpacker_if.slave bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [2:0]       valid;
        logic [2:0][31:0] insn;
        logic [2:0][31:0] addr;
        logic [2:0]       exc;
        logic [2:0]       intr;
        logic [4:0]       ecause;
`ifdef RV_TRACE_TVAL_EN
        logic [31:0]      tval;
`endif
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    logic [1:0]       cursor;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    entry_t     head;
    entry_t     new_entry;
    logic       empty, full, in_valid;
    logic       xfer, last, pop, push, drop;
    logic [1:0] lane, next_lane;
    logic [2:0] after_mask;
    logic       flagged;

    // Lanes at or above lane c.
    function automatic logic [2:0] ge_mask(input logic [1:0] c);
        case (c)
            2'd0:    return 3'b111;
            2'd1:    return 3'b110;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Lowest set lane. The callers only use the result when the mask is non-zero.
    function automatic logic [1:0] lowest(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Packet capture.
    always_comb begin
        // NOTE: every combinational output gets a default first, so that no path
        // leaves a signal unassigned and infers a latch.
        new_entry        = '0;
        new_entry.valid  = bus.trace_rv_i_valid_ip;
        new_entry.insn   = bus.trace_rv_i_insn_ip;
        new_entry.addr   = bus.trace_rv_i_address_ip;
        new_entry.exc    = bus.trace_rv_i_exception_ip;
        new_entry.intr   = bus.trace_rv_i_interrupt_ip;
        new_entry.ecause = bus.trace_rv_i_ecause_ip;
`ifdef RV_TRACE_TVAL_EN
        new_entry.tval   = bus.trace_rv_i_tval_ip;
`endif
    end

`ifndef RV_TRACE_TVAL_EN
    logic unused_tval;
    assign unused_tval = ^bus.trace_rv_i_tval_ip;
`endif

    // Head selection and handshake. A stored entry always has at least one
    // valid lane. The cursor only ever rests on a valid lane, or on 0 for a
    // fresh head, so the selected lane is always valid.
    always_comb begin
        head       = mem[rd_ptr];
        empty      = (level == '0);
        full       = (level == FULL_LVL);
        in_valid   = |bus.trace_rv_i_valid_ip;
        lane       = lowest(head.valid & ge_mask(cursor));
        after_mask = head.valid & ge_mask(lane + 2'd1);
        next_lane  = lowest(after_mask);
        last       = (after_mask == 3'b000);
        xfer       = !empty && bus.out_ready;
        pop        = xfer && last;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts
        // the incoming packet.
        push       = in_valid && (!full || pop);
        drop       = in_valid && full && !pop;
        flagged    = head.exc[lane] | head.intr[lane];
    end

    // Record stream. All outputs read 0 while the FIFO is empty.
    always_comb begin
        bus.out_valid  = !empty;
        bus.out_lane   = '0;
        bus.out_insn   = '0;
        bus.out_addr   = '0;
        bus.out_exc    = 1'b0;
        bus.out_intr   = 1'b0;
        bus.out_ecause = '0;
        bus.out_tval   = '0;
        if (!empty) begin
            bus.out_lane = lane;
            bus.out_insn = head.insn[lane];
            bus.out_addr = head.addr[lane];
            bus.out_exc  = head.exc[lane];
            bus.out_intr = head.intr[lane];
            if (flagged) begin
                bus.out_ecause = head.ecause;
`ifdef RV_TRACE_TVAL_EN
                bus.out_tval   = head.tval;
`endif
            end
        end
    end

    assign bus.fifo_level = level;
    assign bus.drop_cnt   = drop_cnt;
    assign bus.overflow   = overflow;

    // Control state.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment, so every register
        // samples the values that held before the clock edge.
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            cursor   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (xfer) cursor <= last ? 2'd0 : next_lane;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Packet storage.
    // NOTE: the storage array has no reset. An entry is only observed when
    // level counts it, and level always resets.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end
endmodule
